load_align_extend: RTL and testbench
====================================

Name: load_align_extend

Overview:
- Memory-stage load formatter, the parametrised successor of the combinational sign-extend-memory block.
- Takes a load request (byte address, size, signed/unsigned), issues one or two word-aligned memory reads, and merges the returned words.
- Extracts the addressed byte, half, word or double, then zero- or sign-extends it to XLEN.
- Sits between the execute/memory pipeline register and the data-memory port; result goes to writeback through a valid/ready handshake.

Parameters:
- XLEN, 32, datapath and memory word width; legal values 32 or 64. NB = XLEN/8.
- MISALIGN_SPLIT, 1, 1 = a misaligned access crossing a word boundary is split into two reads; 0 = it raises a trap.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  load request present
- req_ready  output  1  block can accept a request
- req_addr  input  XLEN  byte address
- req_size  input  2  00 byte, 01 half, 10 word, 11 double (legal only when XLEN=64)
- req_uns  input  1  1 = zero-extend, 0 = sign-extend
- flush  input  1  abort the current operation
- mem_req_valid  output  1  single-cycle read strobe
- mem_req_addr  output  XLEN  word-aligned read address (low log2(NB) bits = 0)
- mem_rsp_valid  input  1  read data valid
- mem_rsp_data  input  XLEN  read data
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_data  output  XLEN  extended load result
- out_trap  output  1  misaligned or illegal-size trap; qualified by out_valid

Behaviour:
- Clock and reset are fixed: single clock clk; rst is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, mem_req_valid=0, mem_req_addr=0, out_valid=0, out_data=0, out_trap=0. All outputs are registered.
- Derived quantities:
  - bytes = 1/2/4/8 from req_size.
  - off = req_addr mod NB.
  - cross = (off + bytes > NB).
  - illegal = (req_size==11 && XLEN==32).
- Request acceptance: a request is accepted when req_valid && req_ready. The block captures addr, size and uns. req_ready=1 only in IDLE.
- FSM states: IDLE, WAIT1, WAIT2, DONE.
- IDLE, on accept:
  - If illegal, or cross with MISALIGN_SPLIT=0: go to DONE with out_trap=1, out_data=0, and issue no memory read.
  - Otherwise: next cycle mem_req_valid=1 for one cycle with mem_req_addr = addr with the low bits cleared; go to WAIT1.
- WAIT1, on mem_rsp_valid: register lo=mem_rsp_data.
  - If cross: next cycle pulse mem_req_valid with mem_req_addr = aligned addr + NB (wraps modulo 2^XLEN); go to WAIT2.
  - Else: compute the result; go to DONE.
- WAIT2, on mem_rsp_valid: hi=mem_rsp_data; compute the result; go to DONE.
- Result computation:
  - Form the window {hi,lo} (2*XLEN bits; hi=0 when the access does not cross).
  - Shift right by off*8 and take the low bytes*8 bits.
  - If uns=0, replicate the top bit of that field up to XLEN; otherwise zero-fill.
  - Double on XLEN=64 passes through unchanged.
- DONE: out_valid=1 and out_data/out_trap held stable until out_ready. On out_valid && out_ready, go to IDLE next cycle with out_valid=0.
- Latency, aligned access with a response 1 cycle after the strobe:
  - accept at cycle 0, mem_req_valid at cycle 1, rsp at cycle 2, out_valid at cycle 3.
  - A crossing access adds 2 cycles.
- mem_rsp_valid is ignored in IDLE and DONE. The memory never returns more than one response per strobe.
- flush: forces IDLE next cycle from any state and drops out_valid. A response to an already-issued strobe that arrives after flush falls in IDLE and is ignored. flush together with req_valid in IDLE: the request is not accepted.
- rst mid-operation behaves exactly like flush and additionally restores all reset values.
- Back-to-back operation: a new request can be accepted the cycle after the out handshake; there is no overlap.

Test Plan:
- XLEN=32, word[0x1000]=0x8070_60A0: byte at 0x1000, uns=0 -> out_data=0xFFFF_FFA0; uns=1 -> 0x0000_00A0; out_valid exactly 3 cycles after accept with a 1-cycle memory.
- Same word: half at 0x1002, uns=0 -> 0xFFFF_8070; half at 0x1000, uns=1 -> 0x0000_60A0; word at 0x1000 -> 0x8070_60A0.
- MISALIGN_SPLIT=1, word[0x1004]=0x1122_3344: word at 0x1003 -> two strobes (0x1000 then 0x1004); out_data=0x2233_4480; out_trap=0.
- MISALIGN_SPLIT=0: word at 0x1003 -> no mem_req_valid; out_valid with out_trap=1 and out_data=0. XLEN=32 with size=11 -> out_trap=1.
- Hold out_ready=0 for 5 cycles -> out_valid and out_data stay stable and req_ready=0; release -> IDLE and req_ready=1 the next cycle.
- Flush in WAIT1 followed by a late mem_rsp_valid -> no out_valid. rst asserted in WAIT2 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/load_align_extend.sv
// Memory-stage load formatter: issues one or two word-aligned reads for a byte/half/word/double
// load, merges the returned words and zero- or sign-extends the addressed field to XLEN.
module load_align_extend #(
  parameter int XLEN           = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic            req_uns,
  input  logic            flush,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_trap,
  output logic [1:0]      dbg_state
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    WAIT2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              cross_q;
  logic [XLEN-1:0]   lo_q;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid holds with stable payload until that edge. mem_req_valid is a one-cycle strobe
  // with no ready, and each strobe produces exactly one mem_rsp_valid pulse later.

  logic [OFFW-1:0]   req_off;
  logic [3:0]        req_bytes;
  logic [4:0]        req_end;
  logic              req_cross;
  logic              req_illegal;
  logic [XLEN-1:0]   req_aligned;

  always_comb begin
    req_off = req_addr[OFFW-1:0];
    case (req_size)
      2'b00:   req_bytes = 4'd1;
      2'b01:   req_bytes = 4'd2;
      2'b10:   req_bytes = 4'd4;
      default: req_bytes = 4'd8;
    endcase
    req_end     = 5'(req_off) + 5'(req_bytes);
    req_cross   = (req_end > 5'(NB));
    req_illegal = (req_size == 2'b11) && (XLEN == 32);
    req_aligned = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
  end

  // Result path: the window {hi,lo} is shifted down by the byte offset, then masked to the
  // access size; hi is only meaningful on the second response of a split access.
  logic [XLEN-1:0]   win_hi;
  logic [XLEN-1:0]   win_lo;
  logic [OFFW+2:0]   shift_amt;
  logic [XLEN-1:0]   field;
  logic [XLEN-1:0]   mask;
  logic              sbit;
  logic [XLEN-1:0]   result;

  always_comb begin
    win_hi    = (state == WAIT2) ? mem_rsp_data : '0;
    win_lo    = (state == WAIT2) ? lo_q : mem_rsp_data;
    shift_amt = {addr_q[OFFW-1:0], 3'b000};
    field     = XLEN'({win_hi, win_lo} >> shift_amt);
    mask      = '0;
    sbit      = 1'b0;
    case (size_q)
      2'b00: begin
        mask[7:0] = '1;
        sbit      = field[7];
      end
      2'b01: begin
        mask[15:0] = '1;
        sbit       = field[15];
      end
      2'b10: begin
        mask[31:0] = '1;
        sbit       = field[31];
      end
      default: begin
        mask = '1;
        sbit = field[XLEN-1];
      end
    endcase
    result = (field & mask) | ((sbit && !uns_q) ? ~mask : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_trap      <= 1'b0;
      addr_q        <= '0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      cross_q       <= 1'b0;
      lo_q          <= '0;
    end else if (flush) begin
      // Abort: a response to a strobe already on the bus will land in IDLE and be dropped.
      state         <= IDLE;
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      mem_req_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            size_q    <= req_size;
            uns_q     <= req_uns;
            cross_q   <= req_cross;
            req_ready <= 1'b0;
            if (req_illegal || (req_cross && (MISALIGN_SPLIT == 0))) begin
              out_valid <= 1'b1;
              out_trap  <= 1'b1;
              out_data  <= '0;
              state     <= DONE;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= req_aligned;
              state         <= WAIT1;
            end
          end
        end
        WAIT1: begin
          if (mem_rsp_valid) begin
            lo_q <= mem_rsp_data;
            if (cross_q) begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}} + XLEN'(NB);
              state         <= WAIT2;
            end else begin
              out_valid <= 1'b1;
              out_trap  <= 1'b0;
              out_data  <= result;
              state     <= DONE;
            end
          end
        end
        WAIT2: begin
          if (mem_rsp_valid) begin
            out_valid <= 1'b1;
            out_trap  <= 1'b0;
            out_data  <= result;
            state     <= DONE;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_load_align_extend.sv
// Bench for load_align_extend (XLEN=32): one instance splits misaligned loads, the other traps.
module tb_load_align_extend;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_uns;
  logic        flush;
  logic        out_ready;

  logic        req_valid_a     [2];
  logic        req_ready_a     [2];
  logic        mem_req_valid_a [2];
  logic [31:0] mem_req_addr_a  [2];
  logic        mem_rsp_valid_a [2];
  logic [31:0] mem_rsp_data_a  [2];
  logic        out_valid_a     [2];
  logic [31:0] out_data_a      [2];
  logic        out_trap_a      [2];
  logic [1:0]  dbg_state_a     [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] exp_q[$];
  logic [31:0] strobe_q0[$];
  logic [31:0] strobe_q1[$];

  always #5 clk = ~clk;

  load_align_extend #(.XLEN(32), .MISALIGN_SPLIT(1)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]),
    .req_addr(req_addr), .req_size(req_size), .req_uns(req_uns), .flush(flush),
    .mem_req_valid(mem_req_valid_a[0]), .mem_req_addr(mem_req_addr_a[0]),
    .mem_rsp_valid(mem_rsp_valid_a[0]), .mem_rsp_data(mem_rsp_data_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready), .out_data(out_data_a[0]),
    .out_trap(out_trap_a[0]), .dbg_state(dbg_state_a[0])
  );

  load_align_extend #(.XLEN(32), .MISALIGN_SPLIT(0)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]),
    .req_addr(req_addr), .req_size(req_size), .req_uns(req_uns), .flush(flush),
    .mem_req_valid(mem_req_valid_a[1]), .mem_req_addr(mem_req_addr_a[1]),
    .mem_rsp_valid(mem_rsp_valid_a[1]), .mem_rsp_data(mem_rsp_data_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready), .out_data(out_data_a[1]),
    .out_trap(out_trap_a[1]), .dbg_state(dbg_state_a[1])
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'h8070_60A0;
      32'h0000_1004: return 32'h1122_3344;
      default:       return 32'h9E37_79B9 ^ (a * 32'h0100_0193);
    endcase
  endfunction

  // Memory: answers each strobe one cycle later, driven away from the active edge.
  logic        pend  [2];
  logic [31:0] paddr [2];
  for (genvar g = 0; g < 2; g++) begin : g_mem
    always @(posedge clk) begin
      pend[g]  <= mem_req_valid_a[g];
      paddr[g] <= mem_req_addr_a[g];
      if (mem_req_valid_a[g]) begin
        if (g == 0) strobe_q0.push_back(mem_req_addr_a[g]);
        else        strobe_q1.push_back(mem_req_addr_a[g]);
      end
    end
    always @(negedge clk) begin
      mem_rsp_valid_a[g] = pend[g];
      mem_rsp_data_a[g]  = pend[g] ? mem_word(paddr[g]) : 32'h0;
    end
  end

  // Byte-by-byte little-endian reference load.
  function automatic logic [32:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic uns, input bit split);
    int          nbytes;
    logic [31:0] val;
    logic [31:0] a;
    logic [31:0] w;
    nbytes = 1 << size;
    val    = 32'h0;
    if (size == 2'b11) return {1'b1, 32'h0};
    if (!split && (int'(addr[1:0]) + nbytes > 4)) return {1'b1, 32'h0};
    for (int i = 0; i < nbytes; i++) begin
      a = addr + 32'(i);
      w = mem_word({a[31:2], 2'b00});
      val[8*i +: 8] = w[8*a[1:0] +: 8];
    end
    if (!uns && val[8*nbytes-1])
      for (int i = nbytes; i < 4; i++) val[8*i +: 8] = 8'hFF;
    return {1'b0, val};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_load(input int sel, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic exp_trap, input logic [31:0] exp_data,
                          input int exp_lat, input string name);
    int          lat;
    bit          got;
    int          n_strobes;
    logic [32:0] exp;
    logic [31:0] strobes[$];
    n_strobes = exp_trap ? 0 : ((int'(addr[1:0]) + (1 << size) > 4) ? 2 : 1);
    exp_q.push_back({exp_trap, exp_data});
    @(negedge clk);
    strobe_q0.delete();
    strobe_q1.delete();
    req_addr = addr;
    req_size = size;
    req_uns  = uns;
    req_valid_a[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_a[sel] = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (out_valid_a[sel]) got = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
    end
    exp = exp_q.pop_front();
    if (!got) begin
      check({name, " timeout"}, 64'(out_valid_a[sel]), 64'd1);
    end else begin
      check({name, " latency"}, 64'(lat), 64'(exp_lat));
      check({name, " data"}, 64'(out_data_a[sel]), 64'(exp[31:0]));
      check({name, " trap"}, 64'(out_trap_a[sel]), 64'(exp[32]));
    end
    @(posedge clk);
    @(negedge clk);
    strobes = (sel == 0) ? strobe_q0 : strobe_q1;
    check({name, " strobes"}, 64'(strobes.size()), 64'(n_strobes));
    if (strobes.size() >= 1 && n_strobes >= 1)
      check({name, " addr0"}, 64'(strobes[0]), 64'({addr[31:2], 2'b00}));
    if (strobes.size() >= 2 && n_strobes >= 2)
      check({name, " addr1"}, 64'(strobes[1]), 64'({addr[31:2], 2'b00} + 32'd4));
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic        exp_trap;
    logic [31:0] exp_data;
    int          lat;
  } vec_t;

  vec_t        vecs[12];
  logic [32:0] r;
  logic [31:0] ra;
  logic [1:0]  rs;
  logic        ru;
  logic [31:0] held;
  bit          seen;

  initial begin
    vecs[0]  = '{32'h1000, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFA0, 3};
    vecs[1]  = '{32'h1000, 2'b00, 1'b1, 1'b0, 32'h0000_00A0, 3};
    vecs[2]  = '{32'h1002, 2'b01, 1'b0, 1'b0, 32'hFFFF_8070, 3};
    vecs[3]  = '{32'h1000, 2'b01, 1'b1, 1'b0, 32'h0000_60A0, 3};
    vecs[4]  = '{32'h1000, 2'b10, 1'b0, 1'b0, 32'h8070_60A0, 3};
    vecs[5]  = '{32'h1003, 2'b10, 1'b0, 1'b0, 32'h2233_4480, 5};
    vecs[6]  = '{32'h1000, 2'b11, 1'b0, 1'b1, 32'h0000_0000, 1};
    vecs[7]  = '{32'h1003, 2'b00, 1'b0, 1'b0, 32'hFFFF_FF80, 3};
    vecs[8]  = '{32'h1003, 2'b01, 1'b1, 1'b0, 32'h0000_4480, 5};
    vecs[9]  = '{32'h1001, 2'b01, 1'b0, 1'b0, 32'h0000_7060, 3};
    vecs[10] = '{32'h1006, 2'b00, 1'b1, 1'b0, 32'h0000_0022, 3};
    vecs[11] = '{32'h1006, 2'b01, 1'b0, 1'b0, 32'h0000_1122, 3};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    req_addr = 32'h0; req_size = 2'b00; req_uns = 1'b0;
    req_valid_a[0] = 1'b0; req_valid_a[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset req_ready", 64'(req_ready_a[s]), 64'd1);
      check("reset mem_req", 64'({mem_req_valid_a[s], mem_req_addr_a[s]}), 64'd0);
      check("reset out", 64'({out_valid_a[s], out_trap_a[s], out_data_a[s]}), 64'd0);
      check("reset state", 64'(dbg_state_a[s]), 64'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_load(0, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].exp_trap,
               vecs[i].exp_data, vecs[i].lat, $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      ra = 32'h1000 + 32'($urandom_range(0, 11));
      rs = 2'($urandom_range(0, 2));
      ru = 1'($urandom_range(0, 1));
      r  = ref_load(ra, rs, ru, 1'b1);
      run_load(0, ra, rs, ru, r[32], r[31:0],
               (int'(ra[1:0]) + (1 << rs) > 4) ? 5 : 3, $sformatf("rnd%0d", i));
    end

    run_load(1, 32'h1003, 2'b10, 1'b0, 1'b1, 32'h0, 1, "nosplit word");
    run_load(1, 32'h1003, 2'b01, 1'b1, 1'b1, 32'h0, 1, "nosplit half");
    run_load(1, 32'h1002, 2'b01, 1'b0, 1'b0, 32'hFFFF_8070, 3, "nosplit aligned");
    run_load(1, 32'h1000, 2'b11, 1'b1, 1'b1, 32'h0, 1, "nosplit illegal");

    // Output stall: result must hold while out_ready is low.
    out_ready = 1'b0;
    @(negedge clk);
    req_addr = 32'h1002; req_size = 2'b01; req_uns = 1'b0; req_valid_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_a[0] = 1'b0;
    for (int i = 0; i < 20 && !out_valid_a[0]; i++) @(negedge clk);
    check("stall valid", 64'(out_valid_a[0]), 64'd1);
    held = out_data_a[0];
    check("stall data", 64'(held), 64'h0000_0000_FFFF_8070);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall hold", 64'({out_valid_a[0], req_ready_a[0], out_data_a[0]}),
            64'({1'b1, 1'b0, held}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall release", 64'({out_valid_a[0], req_ready_a[0], dbg_state_a[0]}), 64'({1'b0, 1'b1, 2'd0}));

    // Flush in WAIT1; the late response must be ignored.
    req_addr = 32'h1000; req_size = 2'b10; req_uns = 1'b0; req_valid_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_a[0] = 1'b0;
    check("flush in wait1", 64'(dbg_state_a[0]), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid_a[0]) seen = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    check("flush no out", 64'(seen), 64'd0);
    check("flush idle", 64'({req_ready_a[0], dbg_state_a[0]}), 64'({1'b1, 2'd0}));
    run_load(0, 32'h1001, 2'b00, 1'b1, 1'b0, 32'h0000_0060, 3, "after flush");

    // Flush together with a request in IDLE: not accepted.
    @(negedge clk);
    strobe_q0.delete();
    req_addr = 32'h1000; req_size = 2'b00; req_valid_a[0] = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_a[0] = 1'b0; flush = 1'b0;
    check("flush req", 64'({req_ready_a[0], mem_req_valid_a[0], dbg_state_a[0]}), 64'({1'b1, 1'b0, 2'd0}));

    // Reset in WAIT2 of a split access.
    req_addr = 32'h1003; req_size = 2'b10; req_uns = 1'b0; req_valid_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_a[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst in wait2", 64'(dbg_state_a[0]), 64'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst ready", 64'({req_ready_a[0], dbg_state_a[0]}), 64'({1'b1, 2'd0}));
    check("rst mem", 64'({mem_req_valid_a[0], mem_req_addr_a[0]}), 64'd0);
    check("rst out", 64'({out_valid_a[0], out_trap_a[0], out_data_a[0]}), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid_a[0]) seen = 1'b1;
    end
    check("rst late rsp", 64'(seen), 64'd0);
    run_load(0, 32'h1004, 2'b10, 1'b0, 1'b0, 32'h1122_3344, 3, "after rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
